player_clock_core: RTL and testbench

- Sequential chess-clock engine that generates the per-player round and total BCD timers consumed by the on-screen timer renderer.
- Generalised to N players, count-down or count-up mode, and pause/resume, with per-player timeout flags.
- Sits between the game-control FSM (start / turn-switch / pause events) and the pixel pipeline.
- Timer format is 16-bit BCD MM:SS: [15:12] minute tens, [11:8] minute ones, [7:4] second tens, [3:0] second ones.

---
 rtl/player_clock_pkg.sv | 16 +
 rtl/bcd_mmss_step.sv | 62 ++++++
 rtl/player_clock_core.sv | 150 +++++++++++++++
 tb/tb_player_clock_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/player_clock_pkg.sv
// Shared types and constants for the chess-clock engine.
package player_clock_pkg;

  localparam int unsigned BCD_W = 16;

  localparam logic [BCD_W-1:0] BCD_ZERO = 16'h0000;
  localparam logic [BCD_W-1:0] BCD_MAX  = 16'h9959;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_TIMEOUT
  } state_t;

endpackage

// File: rtl/bcd_mmss_step.sv
// Saturating one-second step of a BCD MM:SS value (dir=1 decrements, dir=0 increments).
module bcd_mmss_step
  import player_clock_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  input  logic             dir,
  output logic [BCD_W-1:0] next,
  output logic             is_zero
);

  logic [3:0] s1, s10, m1, m10;

  always_comb begin
    s1   = value[3:0];
    s10  = value[7:4];
    m1   = value[11:8];
    m10  = value[15:12];
    next = value;
    if (dir) begin
      if (value != BCD_ZERO) begin
        if (s1 != 4'd0) begin
          s1 = s1 - 4'd1;
        end else begin
          s1 = 4'd9;
          if (s10 != 4'd0) begin
            s10 = s10 - 4'd1;
          end else begin
            s10 = 4'd5;
            if (m1 != 4'd0) begin
              m1 = m1 - 4'd1;
            end else begin
              m1  = 4'd9;
              m10 = m10 - 4'd1;
            end
          end
        end
        next = {m10, m1, s10, s1};
      end
    end else if (value != BCD_MAX) begin
      if (s1 != 4'd9) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (s10 != 4'd5) begin
          s10 = s10 + 4'd1;
        end else begin
          s10 = 4'd0;
          if (m1 != 4'd9) begin
            m1 = m1 + 4'd1;
          end else begin
            m1  = 4'd0;
            m10 = m10 + 4'd1;
          end
        end
      end
      next = {m10, m1, s10, s1};
    end
  end

  assign is_zero = (next == BCD_ZERO);

endmodule

// File: rtl/player_clock_core.sv
// N-player chess-clock engine: prescaled one-second ticks step the active
// player's round and total BCD timers, with pause/resume and sticky timeouts.
module player_clock_core
  import player_clock_pkg::*;
#(
  parameter int unsigned N_PLAYER   = 2,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned COUNT_DOWN = 1,
  parameter logic [15:0] ROUND_INIT = 16'h0100,
  parameter logic [15:0] TOTAL_INIT = 16'h1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        resume,
  input  logic                        switch_turn,
  output logic [$clog2(N_PLAYER)-1:0] active,
  output logic [16*N_PLAYER-1:0]      rnd_bcd,
  output logic [16*N_PLAYER-1:0]      tot_bcd,
  output logic [N_PLAYER-1:0]         timeout,
  output logic                        running,
  output logic                        tick
);

  localparam int unsigned AW = $clog2(N_PLAYER);
  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic             DIR_DOWN    = (COUNT_DOWN != 0);
  localparam logic [BCD_W-1:0] RND_RST     = DIR_DOWN ? ROUND_INIT : BCD_ZERO;
  localparam logic [BCD_W-1:0] TOT_RST     = DIR_DOWN ? TOTAL_INIT : BCD_ZERO;
  localparam logic [PW-1:0]    PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0]    LAST_PLAYER = AW'(N_PLAYER - 1);

  state_t                  state, state_nxt;
  logic [PW-1:0]           pre, pre_nxt;
  logic [AW-1:0]           active_nxt, next_player;
  logic [16*N_PLAYER-1:0]  rnd_nxt, tot_nxt;
  logic [N_PLAYER-1:0]     timeout_nxt;
  logic                    tick_nxt, fire, expired;
  logic [BCD_W-1:0]        cur_rnd, cur_tot, rnd_step, tot_step;
  logic                    rnd_zero, tot_zero;

  always_comb begin
    cur_rnd = '0;
    cur_tot = '0;
    for (int unsigned p = 0; p < N_PLAYER; p++) begin
      if (active == AW'(p)) begin
        cur_rnd = rnd_bcd[16*p +: 16];
        cur_tot = tot_bcd[16*p +: 16];
      end
    end
  end

  bcd_mmss_step u_rnd_step (
    .value   (cur_rnd),
    .dir     (DIR_DOWN),
    .next    (rnd_step),
    .is_zero (rnd_zero)
  );

  bcd_mmss_step u_tot_step (
    .value   (cur_tot),
    .dir     (DIR_DOWN),
    .next    (tot_step),
    .is_zero (tot_zero)
  );

  always_comb begin
    state_nxt   = state;
    pre_nxt     = pre;
    active_nxt  = active;
    rnd_nxt     = rnd_bcd;
    tot_nxt     = tot_bcd;
    timeout_nxt = timeout;
    tick_nxt    = 1'b0;
    fire        = 1'b0;
    expired     = 1'b0;
    next_player = (active == LAST_PLAYER) ? '0 : active + AW'(1);

    if (start) begin
      state_nxt   = ST_RUN;
      pre_nxt     = '0;
      active_nxt  = '0;
      rnd_nxt     = {N_PLAYER{RND_RST}};
      tot_nxt     = {N_PLAYER{TOT_RST}};
      timeout_nxt = '0;
    end else begin
      case (state)
        ST_RUN: begin
          fire    = (pre == PRE_LAST);
          pre_nxt = fire ? '0 : pre + PW'(1);
          if (fire) begin
            tick_nxt = 1'b1;
            expired  = DIR_DOWN && (rnd_zero || tot_zero);
            for (int unsigned p = 0; p < N_PLAYER; p++) begin
              if (active == AW'(p)) begin
                rnd_nxt[16*p +: 16] = rnd_step;
                tot_nxt[16*p +: 16] = tot_step;
              end
            end
          end
          // The outgoing player's step lands first; a timeout swallows any switch or pause.
          if (expired) begin
            state_nxt = ST_TIMEOUT;
            for (int unsigned p = 0; p < N_PLAYER; p++) begin
              if (active == AW'(p)) timeout_nxt[p] = 1'b1;
            end
          end else begin
            if (switch_turn) begin
              active_nxt = next_player;
              pre_nxt    = '0;
              for (int unsigned p = 0; p < N_PLAYER; p++) begin
                if (next_player == AW'(p)) rnd_nxt[16*p +: 16] = RND_RST;
              end
            end
            if (pause) state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (resume) state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pre     <= '0;
      active  <= '0;
      rnd_bcd <= {N_PLAYER{RND_RST}};
      tot_bcd <= {N_PLAYER{TOT_RST}};
      timeout <= '0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre     <= pre_nxt;
      active  <= active_nxt;
      rnd_bcd <= rnd_nxt;
      tot_bcd <= tot_nxt;
      timeout <= timeout_nxt;
      tick    <= tick_nxt;
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_player_clock_core.sv
// Bench for player_clock_core: three configurations share one stimulus stream
// and are checked every cycle against a seconds-based behavioural model.
module tb_player_clock_core;

  logic clk = 1'b0;
  logic rst, start, pause, resume, switch_turn;
  always #5 clk = ~clk;

  logic [0:0]  a0, a2;
  logic [1:0]  a1;
  logic [31:0] r0, t0, r2, t2;
  logic [47:0] r1, t1;
  logic [1:0]  to0, to2;
  logic [2:0]  to1;
  logic        run0, run1, run2, tk0, tk1, tk2;

  player_clock_core #(.N_PLAYER(2), .TICK_DIV(4), .COUNT_DOWN(1),
                      .ROUND_INIT(16'h0100), .TOTAL_INIT(16'h1000)) u0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .resume(resume),
    .switch_turn(switch_turn), .active(a0), .rnd_bcd(r0), .tot_bcd(t0),
    .timeout(to0), .running(run0), .tick(tk0));

  player_clock_core #(.N_PLAYER(3), .TICK_DIV(3), .COUNT_DOWN(1),
                      .ROUND_INIT(16'h0002), .TOTAL_INIT(16'h0010)) u1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .resume(resume),
    .switch_turn(switch_turn), .active(a1), .rnd_bcd(r1), .tot_bcd(t1),
    .timeout(to1), .running(run1), .tick(tk1));

  player_clock_core #(.N_PLAYER(2), .TICK_DIV(2), .COUNT_DOWN(0),
                      .ROUND_INIT(16'h0100), .TOTAL_INIT(16'h1000)) u2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .resume(resume),
    .switch_turn(switch_turn), .active(a2), .rnd_bcd(r2), .tot_bcd(t2),
    .timeout(to2), .running(run2), .tick(tk2));

  logic [47:0] r_all[3], t_all[3];
  logic [2:0]  to_all[3];
  logic [1:0]  act_all[3];
  logic        run_all[3], tk_all[3];

  assign r_all[0] = {16'h0, r0};  assign r_all[1] = r1;  assign r_all[2] = {16'h0, r2};
  assign t_all[0] = {16'h0, t0};  assign t_all[1] = t1;  assign t_all[2] = {16'h0, t2};
  assign to_all[0] = {1'b0, to0}; assign to_all[1] = to1; assign to_all[2] = {1'b0, to2};
  assign act_all[0] = {1'b0, a0}; assign act_all[1] = a1; assign act_all[2] = {1'b0, a2};
  assign run_all[0] = run0; assign run_all[1] = run1; assign run_all[2] = run2;
  assign tk_all[0] = tk0;   assign tk_all[1] = tk1;   assign tk_all[2] = tk2;

  // Model configuration: timer values are kept as plain seconds.
  int np[3]    = '{2, 3, 2};
  int div[3]   = '{4, 3, 2};
  int down[3]  = '{1, 1, 0};
  int rin_s[3] = '{60, 2, 0};
  int tin_s[3] = '{600, 10, 0};
  localparam int MAX_S = 99 * 60 + 59;

  // Model state: 0 idle, 1 run, 2 pause, 3 timed out.
  int mst[3], mpre[3], mact[3];
  int mr[3][3], mt[3][3];
  bit mto[3][3];
  bit mtick[3];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic logic [15:0] s2bcd(input int s);
    int m, sec;
    m = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reload(input int k);
    mpre[k] = 0;
    mact[k] = 0;
    for (int p = 0; p < 3; p++) begin
      mr[k][p]  = rin_s[k];
      mt[k][p]  = tin_s[k];
      mto[k][p] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit fire, gone;
    int a;
    fire = 1'b0;
    gone = 1'b0;
    a = mact[k];
    mtick[k] = 1'b0;
    if (rst) begin
      model_reload(k);
      mst[k] = 0;
    end else if (start) begin
      model_reload(k);
      mst[k] = 1;
    end else if (mst[k] == 1) begin
      fire = (mpre[k] == div[k] - 1);
      mpre[k] = fire ? 0 : mpre[k] + 1;
      if (fire) begin
        mtick[k] = 1'b1;
        if (down[k] != 0) begin
          if (mr[k][a] > 0) mr[k][a]--;
          if (mt[k][a] > 0) mt[k][a]--;
          gone = (mr[k][a] == 0) || (mt[k][a] == 0);
        end else begin
          if (mr[k][a] < MAX_S) mr[k][a]++;
          if (mt[k][a] < MAX_S) mt[k][a]++;
        end
      end
      if (gone) begin
        mto[k][a] = 1'b1;
        mst[k] = 3;
      end else begin
        if (switch_turn) begin
          mact[k] = (a + 1) % np[k];
          mr[k][mact[k]] = rin_s[k];
          mpre[k] = 0;
        end
        if (pause) mst[k] = 2;
      end
    end else if (mst[k] == 2 && resume) begin
      mst[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [2:0] exp_to;
        exp_to = '0;
        for (int p = 0; p < np[k]; p++) begin
          exp_to[p] = mto[k][p];
          chk($sformatf("u%0d rnd%0d", k, p), 48'(r_all[k][16*p +: 16]), 48'(s2bcd(mr[k][p])));
          chk($sformatf("u%0d tot%0d", k, p), 48'(t_all[k][16*p +: 16]), 48'(s2bcd(mt[k][p])));
        end
        chk($sformatf("u%0d active", k), 48'(act_all[k]), 48'(mact[k]));
        chk($sformatf("u%0d timeout", k), 48'(to_all[k]), 48'(exp_to));
        chk($sformatf("u%0d running", k), 48'(run_all[k]), 48'(mst[k] == 1));
        chk($sformatf("u%0d tick", k), 48'(tk_all[k]), 48'(mtick[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0; switch_turn = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    chk("lit reset rnd u0", 48'(r0), 48'h0100_0100);
    chk("lit reset tot u0", 48'(t0), 48'h1000_1000);
    chk("lit reset rnd u2", 48'(r2), 48'h0);
    chk("lit reset run u0", 48'(run0), 48'h0);

    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    chk("lit first tick", 48'(tk0), 48'h1);
    chk("lit first rnd0", 48'(r0[15:0]), 48'h0059);
    chk("lit first tot0", 48'(t0[15:0]), 48'h0959);
    chk("lit first rnd1", 48'(r0[31:16]), 48'h0100);

    repeat (11) cyc();
    switch_turn = 1'b1; cyc(); switch_turn = 1'b0;
    chk("lit switch rnd0", 48'(r0[15:0]), 48'h0056);
    chk("lit switch tot0", 48'(t0[15:0]), 48'h0956);
    chk("lit switch active", 48'(a0), 48'h1);
    chk("lit switch rnd1", 48'(r0[31:16]), 48'h0100);
    chk("lit timeout flags", 48'(to1), 48'h1);
    chk("lit timeout running", 48'(run1), 48'h0);
    chk("lit timeout rnd0", 48'(r1[15:0]), 48'h0000);
    chk("lit timeout tot0", 48'(t1[15:0]), 48'h0008);
    repeat (3) cyc();
    chk("lit no early tick", 48'(tk0), 48'h0);
    cyc();
    chk("lit tick after switch", 48'(tk0), 48'h1);
    chk("lit rnd1 after switch", 48'(r0[31:16]), 48'h0059);

    cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("lit paused", 48'(run0), 48'h0);
    repeat (10) cyc();
    chk("lit pause hold rnd1", 48'(r0[31:16]), 48'h0059);
    chk("lit pause hold rnd0", 48'(r0[15:0]), 48'h0056);
    resume = 1'b1; cyc(); resume = 1'b0;
    chk("lit resumed", 48'(run0), 48'h1);
    chk("lit resume tick0", 48'(tk0), 48'h0);
    cyc();
    chk("lit resume tick1", 48'(tk0), 48'h0);
    cyc();
    chk("lit resume tick2", 48'(tk0), 48'h1);
    chk("lit resume rnd1", 48'(r0[31:16]), 48'h0058);

    start = 1'b1; cyc(); start = 1'b0;
    chk("lit start clears timeout", 48'(to1), 48'h0);
    switch_turn = 1'b1;
    cyc(); chk("lit n3 active a", 48'(a1), 48'h1);
    cyc(); chk("lit n3 active b", 48'(a1), 48'h2);
    cyc(); chk("lit n3 active c", 48'(a1), 48'h0);
    chk("lit n2 active c", 48'(a0), 48'h1);
    switch_turn = 1'b0;

    for (int i = 0; i < 20000; i++) begin
      rst         = ($urandom_range(0, 1999) == 0);
      start       = ($urandom_range(0, 299) == 0);
      pause       = ($urandom_range(0, 39) == 0);
      resume      = ($urandom_range(0, 19) == 0);
      switch_turn = ($urandom_range(0, 14) == 0);
      cyc();
    end
    rst = 1'b0; pause = 1'b0; resume = 1'b0; switch_turn = 1'b0;

    start = 1'b1; cyc(); start = 1'b0;
    repeat (118) cyc();
    chk("lit up rnd 0059", 48'(r2[15:0]), 48'h0059);
    repeat (2) cyc();
    chk("lit up rnd 0100", 48'(r2[15:0]), 48'h0100);
    repeat (11900) cyc();
    chk("lit up tot sat", 48'(t2[15:0]), 48'h9959);
    chk("lit up rnd sat", 48'(r2[15:0]), 48'h9959);
    chk("lit up no timeout", 48'(to2), 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
